// File: rtl/poly1305_pkg.sv
// Shared types and sizes for the Poly1305 block packer.
// Imported by the packer top and its byte lane buffer.
package poly1305_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_BITS  = 128;
    localparam int COUNT_W     = 5;

    typedef enum logic [1:0] {
        FILL,
        ISSUE,
        WAIT
    } state_t;

endpackage

// File: rtl/poly1305_byte_lane_buffer.sv
// 16x8 byte lane register with indexed write and clear-all.
// Lane k is presented at bits [8k+7:8k] of the output vector.
module poly1305_byte_lane_buffer
    import poly1305_pkg::*;
(
    input  logic                  clock,
    input  logic                  i_clear_all,
    input  logic                  i_wr_en,
    input  logic [3:0]            i_wr_idx,
    input  logic [7:0]            i_wr_data,
    output logic [BLOCK_BITS-1:0] o_vec
);

    logic [7:0] r_lane [BLOCK_BYTES];

    always_ff @(posedge clock) begin
        if (i_clear_all) begin
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                r_lane[k] <= 8'h00;
            end
        end else if (i_wr_en) begin
            r_lane[i_wr_idx] <= i_wr_data;
        end
    end

    always_comb begin
        o_vec = '0;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            o_vec[8*k +: 8] = r_lane[k];
        end
    end

endmodule

// File: rtl/poly1305_block_packer.sv
// Packs a byte stream little-endian into 16-byte blocks for the
// Poly1305 serial encoder, pacing starts by the encoder round time.
module poly1305_block_packer
    import poly1305_pkg::*;
#(
    parameter int ROUND_CYCLES = 5
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [BLOCK_BITS-1:0] round_input,
    output logic [3:0]            number_of_input_bytes_minus_one,
    output logic                  start,
    output logic                  message_done
);

    state_t               r_state;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_last;
    logic [7:0]           r_wait;
    logic [BLOCK_BITS-1:0] r_round_input;
    logic [3:0]           r_nbm1;
    logic                 r_start;
    logic                 r_done;

    logic                  w_accept;
    logic                  w_final;
    logic                  w_wait_done;
    logic                  w_buf_clear;
    logic [BLOCK_BITS-1:0] w_buf;
    logic [BLOCK_BITS-1:0] w_merged;

    assign in_ready    = (r_state == FILL) && !clear;
    assign w_accept    = in_valid && in_ready;
    assign w_final     = w_accept &&
                         ((r_count == COUNT_W'(15)) || in_last);
    assign w_wait_done = (r_state == WAIT) && (r_wait == 8'd1);
    assign w_buf_clear = clear || w_wait_done;

    // The arriving byte lands in a lane that is still zero, so OR merges
    // it into the snapshot taken on the same edge it is written.
    assign w_merged = w_buf |
                      (BLOCK_BITS'(in_data) << {r_count[3:0], 3'b000});

    poly1305_byte_lane_buffer u_buf (
        .clock       (clock),
        .i_clear_all (w_buf_clear),
        .i_wr_en     (w_accept),
        .i_wr_idx    (r_count[3:0]),
        .i_wr_data   (in_data),
        .o_vec       (w_buf)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state       <= FILL;
            r_count       <= '0;
            r_last        <= 1'b0;
            r_wait        <= 8'd0;
            r_round_input <= '0;
            r_nbm1        <= 4'd0;
            r_start       <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_count <= r_count + COUNT_W'(1);
                        r_last  <= in_last;
                        if (w_final) begin
                            r_state       <= ISSUE;
                            r_start       <= 1'b1;
                            r_round_input <= w_merged;
                            r_nbm1        <= r_count[3:0];
                        end
                    end
                end
                ISSUE: begin
                    r_wait  <= 8'(ROUND_CYCLES);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_wait == 8'd1) begin
                        r_state <= FILL;
                        r_count <= '0;
                        r_done  <= r_last;
                        r_last  <= 1'b0;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign round_input                     = r_round_input;
    assign number_of_input_bytes_minus_one = r_nbm1;
    assign start                           = r_start;
    assign message_done                    = r_done;

endmodule

// File: tb/tb_poly1305_block_packer.sv
// Directed bench for poly1305_block_packer: block contents, counts,
// start/message_done timing, back-pressure and clear recovery.
module tb_poly1305_block_packer;

    localparam int R = 5;

    logic         clock;
    logic         clear;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic [127:0] round_input;
    logic [3:0]   nbm1;
    logic         start;
    logic         message_done;

    poly1305_block_packer #(.ROUND_CYCLES(R)) dut (
        .clock                           (clock),
        .clear                           (clear),
        .in_valid                        (in_valid),
        .in_data                         (in_data),
        .in_last                         (in_last),
        .in_ready                        (in_ready),
        .round_input                     (round_input),
        .number_of_input_bytes_minus_one (nbm1),
        .start                           (start),
        .message_done                    (message_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int           st_cyc [$];
    logic [127:0] st_data [$];
    logic [3:0]   st_cnt [$];
    int           md_cyc [$];
    logic [7:0]   acc [$];
    int           unstable = 0;
    int           busy_rdy = 0;
    int           last_st  = 0;
    bit           have_st  = 0;
    bit           prev_clr = 0;
    logic [127:0] ref_ri   = '0;
    logic [3:0]   ref_n    = '0;

    always @(negedge clock) begin
        if (start) begin
            st_cyc.push_back(cyc);
            st_data.push_back(round_input);
            st_cnt.push_back(nbm1);
            last_st = cyc;
            have_st = 1;
            ref_ri  = round_input;
            ref_n   = nbm1;
        end else if (clear || prev_clr) begin
            ref_ri  = round_input;
            ref_n   = nbm1;
            have_st = 0;
        end else if (round_input !== ref_ri || nbm1 !== ref_n) begin
            unstable++;
        end
        if (in_ready && have_st && (cyc - last_st) <= R) busy_rdy++;
        if (message_done) md_cyc.push_back(cyc);
        if (in_valid && in_ready) acc.push_back(in_data);
        prev_clr = clear;
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_logs();
        st_cyc.delete();
        st_data.delete();
        st_cnt.delete();
        md_cyc.delete();
        acc.delete();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called at posedge+1; returns one cycle after the accepting edge.
    task automatic put_byte(input logic [7:0] b, input logic last);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        #1;
        while (!in_ready && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 100) chk("ready_timeout", 1, 0);
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        #1;
        chk("ready_in_clear", in_ready, 0);
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    int n;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_ri", round_input, 0);
        chk("rst_n", nbm1, 0);
        chk("rst_start", start, 0);
        chk("rst_done", message_done, 0);
        clear = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_ri", round_input, 0);
        chk("post_rst_start", start, 0);
        chk("post_rst_ready", in_ready, 1);

        // full 16-byte message
        clr_logs();
        for (int i = 0; i < 16; i++) put_byte(8'(i), i == 15);
        idle(R + 4);
        chk("t1_starts", st_cyc.size(), 1);
        chk("t1_ri", st_data[0],
            128'h0F0E0D0C0B0A09080706050403020100);
        chk("t1_n", st_cnt[0], 15);
        chk("t1_dones", md_cyc.size(), 1);
        if (md_cyc.size() == 1)
            chk("t1_done_lat", md_cyc[0] - st_cyc[0], R + 1);

        // short 3-byte message
        clr_logs();
        put_byte(8'hAA, 0);
        put_byte(8'hBB, 0);
        put_byte(8'hCC, 1);
        idle(R + 4);
        chk("t2_starts", st_cyc.size(), 1);
        chk("t2_ri", st_data[0], 128'hCCBBAA);
        chk("t2_n", st_cnt[0], 2);
        chk("t2_dones", md_cyc.size(), 1);

        // 17 bytes with in_valid held through ISSUE/WAIT
        clr_logs();
        for (int i = 0; i < 16; i++) put_byte(8'(i), 0);
        put_byte(8'h10, 1);
        idle(R + 4);
        chk("t3_starts", st_cyc.size(), 2);
        if (st_cyc.size() == 2) begin
            chk("t3_gap", st_cyc[1] - st_cyc[0], R + 2);
            chk("t3_ri0", st_data[0],
                128'h0F0E0D0C0B0A09080706050403020100);
            chk("t3_ri1", st_data[1], 128'h10);
            chk("t3_n1", st_cnt[1], 0);
            chk("t3_dones", md_cyc.size(), 1);
            if (md_cyc.size() == 1)
                chk("t3_done_cyc", md_cyc[0], st_cyc[1] + R + 1);
        end
        chk("t3_acc_n", acc.size(), 17);
        n = 0;
        foreach (acc[i]) if (acc[i] != 8'(i)) n++;
        chk("t3_acc_data", n, 0);
        chk("t3_busy_ready", busy_rdy, 0);

        // 20 bytes with random idle gaps
        clr_logs();
        for (int i = 0; i < 20; i++) begin
            put_byte(8'(i), i == 19);
            idle($urandom_range(0, 3));
        end
        idle(R + 4);
        chk("t4_starts", st_cyc.size(), 2);
        if (st_cyc.size() == 2) begin
            chk("t4_ri0", st_data[0],
                128'h0F0E0D0C0B0A09080706050403020100);
            chk("t4_n0", st_cnt[0], 15);
            chk("t4_ri1", st_data[1], 128'h13121110);
            chk("t4_n1", st_cnt[1], 3);
        end
        chk("t4_dones", md_cyc.size(), 1);
        chk("t4_stable", unstable, 0);

        // clear during WAIT of the first block
        clr_logs();
        for (int i = 0; i < 16; i++) put_byte(8'(i), 0);
        idle(2);
        pulse_clear();
        idle(R + 6);
        chk("t5_starts", st_cyc.size(), 1);
        chk("t5_dones", md_cyc.size(), 0);
        clr_logs();
        put_byte(8'h11, 0);
        put_byte(8'h22, 1);
        idle(R + 4);
        chk("t5_starts2", st_cyc.size(), 1);
        chk("t5_ri", st_data[0], 128'h2211);
        chk("t5_n", st_cnt[0], 1);
        chk("t5_dones2", md_cyc.size(), 1);

        // clear in FILL after 5 bytes, byte offered during clear
        clr_logs();
        for (int i = 0; i < 5; i++) put_byte(8'(8'hA0 + i), 0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        pulse_clear();
        in_valid = 1'b0;
        put_byte(8'hEE, 1);
        idle(R + 4);
        chk("t6_starts", st_cyc.size(), 1);
        chk("t6_ri", st_data[0], 128'hEE);
        chk("t6_n", st_cnt[0], 0);
        chk("t6_dones", md_cyc.size(), 1);
        chk("t6_acc_n", acc.size(), 6);
        chk("t6_busy_ready", busy_rdy, 0);
        chk("t6_stable", unstable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
